// File: rtl/zfomove_sprite_fetch.sv
// Pixel-fetch stage for the fighter "move" sprite: box hit test, mirroring,
// animation frame selection and sprite ROM addressing with a 2-clock latency.
module zfomove_sprite_fetch #(
   parameter int SPR_W      = 64,
   parameter int SPR_H      = 96,
   parameter int FRAMES     = 4,
   parameter int FRAME_HOLD = 6,
   parameter int ADDR_W     = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              anim_en,
   input  logic [9:0]        spr_x,
   input  logic [9:0]        spr_y,
   input  logic              face_left,
   input  logic              draw_en,
   input  logic [9:0]        draw_x,
   input  logic [9:0]        draw_y,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_q,
   output logic [3:0]        pal_index,
   output logic              pix_valid
);

   localparam int COL_W   = $clog2(SPR_W);
   localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   logic [9:0]         lx;
   logic [9:0]         ly;
   logic               lface;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [FRAME_W-1:0] frame_idx;
   logic [10:0]        dx;
   logic [10:0]        dy;
   logic               hit;
   logic               hit_d1;
   logic [COL_W-1:0]   col;
   logic [ADDR_W-1:0]  addr_next;

   // Zero-extended subtraction: a negative offset sets bit 10, so a pixel
   // left of or above the box can never alias into it.
   assign dx  = {1'b0, draw_x} - {1'b0, lx};
   assign dy  = {1'b0, draw_y} - {1'b0, ly};
   assign hit = draw_en & ~dx[10] & (dx[9:0] < 10'(SPR_W))
                        & ~dy[10] & (dy[9:0] < 10'(SPR_H));

   assign col = lface ? (COL_W'(SPR_W - 1) - dx[COL_W-1:0]) : dx[COL_W-1:0];

   assign addr_next = ADDR_W'(frame_idx) * ADDR_W'(SPR_W * SPR_H)
                    + ADDR_W'(dy[9:0]) * ADDR_W'(SPR_W)
                    + ADDR_W'(col);

   // Shadow copies and animation counters only move at frame_start, so a
   // pixel drawn in the same cycle still sees the previous frame's values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lx        <= '0;
         ly        <= '0;
         lface     <= 1'b0;
         hold_cnt  <= '0;
         frame_idx <= '0;
      end else if (frame_start) begin
         lx    <= spr_x;
         ly    <= spr_y;
         lface <= face_left;
         if (!anim_en) begin
            hold_cnt  <= '0;
            frame_idx <= '0;
         end else if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
            hold_cnt <= '0;
            if (frame_idx == FRAME_W'(FRAMES - 1))
               frame_idx <= '0;
            else
               frame_idx <= frame_idx + 1'b1;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   // Address is held on misses so the ROM sees no spurious activity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr  <= '0;
         hit_d1    <= 1'b0;
         pal_index <= 4'd0;
         pix_valid <= 1'b0;
      end else begin
         if (hit)
            rom_addr <= addr_next;
         hit_d1    <= hit;
         pal_index <= hit_d1 ? rom_q : 4'd0;
         pix_valid <= hit_d1 & (rom_q != 4'd0);
      end
   end

endmodule

// File: tb/tb_zfomove_sprite_fetch.sv
// Directed bench for zfomove_sprite_fetch with a behavioural sprite ROM.
module tb_zfomove_sprite_fetch;

   logic        clk;
   logic        rst_n;
   logic        frame_start;
   logic        anim_en;
   logic [9:0]  spr_x;
   logic [9:0]  spr_y;
   logic        face_left;
   logic        draw_en;
   logic [9:0]  draw_x;
   logic [9:0]  draw_y;
   logic [14:0] rom_addr;
   logic [3:0]  rom_q;
   logic [3:0]  pal_index;
   logic        pix_valid;

   int          checks;
   int          failures;
   logic [14:0] zero_addr;

   zfomove_sprite_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_start(frame_start),
      .anim_en    (anim_en),
      .spr_x      (spr_x),
      .spr_y      (spr_y),
      .face_left  (face_left),
      .draw_en    (draw_en),
      .draw_x     (draw_x),
      .draw_y     (draw_y),
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .pal_index  (pal_index),
      .pix_valid  (pix_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sprite ROM contents: never 0 except at one programmable colour-key address.
   function automatic logic [3:0] romf(input logic [14:0] a);
      if (a == zero_addr)
         return 4'd0;
      return 4'((int'(a) % 15) + 1);
   endfunction

   always_comb rom_q = romf(rom_addr);

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic pulseFrame(input int x, input int y, input logic face, input logic anim);
      spr_x       = 10'(x);
      spr_y       = 10'(y);
      face_left   = face;
      anim_en     = anim;
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
   endtask

   // One pixel through both stages; on a miss expAddr is the held address.
   task automatic applyStimulus(input string tag, input int x, input int y,
                                input int expAddr, input logic expHit);
      logic [3:0] q;
      draw_x  = 10'(x);
      draw_y  = 10'(y);
      draw_en = 1'b1;
      @(posedge clk);
      #1;
      draw_en = 1'b0;
      checkOutput({tag, ".addr"}, int'(rom_addr), expAddr);
      @(posedge clk);
      #1;
      q = romf(15'(expAddr));
      checkOutput({tag, ".pal"}, int'(pal_index), expHit ? int'(q) : 0);
      checkOutput({tag, ".valid"}, int'(pix_valid), (expHit && q != 4'd0) ? 1 : 0);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      zero_addr   = 15'h7fff;
      rst_n       = 1'b0;
      frame_start = 1'b0;
      anim_en     = 1'b0;
      spr_x       = '0;
      spr_y       = '0;
      face_left   = 1'b0;
      draw_en     = 1'b0;
      draw_x      = '0;
      draw_y      = '0;
      #22;
      checkOutput("reset.addr", int'(rom_addr), 0);
      checkOutput("reset.pal", int'(pal_index), 0);
      checkOutput("reset.valid", int'(pix_valid), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Box corners and edges, frame 0, no mirror
      pulseFrame(100, 50, 1'b0, 1'b0);
      applyStimulus("corner_tl", 100, 50, 0, 1'b1);
      applyStimulus("corner_br", 163, 145, 6143, 1'b1);
      applyStimulus("edge_right", 164, 50, 6143, 1'b0);
      applyStimulus("edge_left", 99, 50, 6143, 1'b0);
      applyStimulus("edge_bottom", 100, 146, 6143, 1'b0);

      pulseFrame(600, 50, 1'b0, 1'b0);
      applyStimulus("offscreen_right", 639, 50, 39, 1'b1);
      applyStimulus("no_wrap", 10, 50, 39, 1'b0);

      pulseFrame(100, 50, 1'b1, 1'b0);
      applyStimulus("mirror_left", 100, 50, 63, 1'b1);
      applyStimulus("mirror_right", 163, 50, 0, 1'b1);

      // Animation: 6 pulses per frame, 4 frames
      for (int i = 0; i < 5; i++) pulseFrame(100, 50, 1'b0, 1'b1);
      applyStimulus("anim_hold5", 100, 50, 0, 1'b1);
      pulseFrame(100, 50, 1'b0, 1'b1);
      applyStimulus("anim_frame1", 100, 50, 6144, 1'b1);
      for (int i = 0; i < 12; i++) pulseFrame(100, 50, 1'b0, 1'b1);
      applyStimulus("anim_frame3", 100, 50, 18432, 1'b1);
      for (int i = 0; i < 6; i++) pulseFrame(100, 50, 1'b0, 1'b1);
      applyStimulus("anim_wrap", 100, 50, 0, 1'b1);
      for (int i = 0; i < 6; i++) pulseFrame(100, 50, 1'b0, 1'b1);
      applyStimulus("anim_again1", 101, 50, 6145, 1'b1);
      pulseFrame(100, 50, 1'b0, 1'b0);
      applyStimulus("anim_clear", 101, 50, 1, 1'b1);

      // Shadow registers ignore mid-frame changes
      spr_x = 10'd200;
      applyStimulus("latch_old", 100, 50, 0, 1'b1);
      applyStimulus("latch_new_miss", 201, 51, 0, 1'b0);

      // frame_start coincident with a drawn pixel uses the old position
      spr_x       = 10'd200;
      spr_y       = 10'd50;
      face_left   = 1'b0;
      anim_en     = 1'b0;
      frame_start = 1'b1;
      draw_x      = 10'd110;
      draw_y      = 10'd50;
      draw_en     = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      draw_en     = 1'b0;
      checkOutput("coincident.addr", int'(rom_addr), 10);
      @(posedge clk);
      #1;
      checkOutput("coincident.pal", int'(pal_index), int'(romf(15'd10)));
      checkOutput("coincident.valid", int'(pix_valid), 1);
      applyStimulus("moved_old_miss", 110, 50, 10, 1'b0);
      applyStimulus("moved_new_hit", 201, 51, 65, 1'b1);

      zero_addr = 15'd130;
      applyStimulus("colour_key", 202, 52, 130, 1'b1);
      zero_addr = 15'h7fff;

      // Reset mid-line with a hit in flight, mirrored frame 1 latched
      for (int i = 0; i < 6; i++) pulseFrame(100, 60, 1'b1, 1'b1);
      draw_x  = 10'd110;
      draw_y  = 10'd60;
      draw_en = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("inflight.addr", int'(rom_addr), 6144 + 53);
      @(posedge clk);
      #1;
      checkOutput("inflight.valid", int'(pix_valid), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset.addr", int'(rom_addr), 0);
      checkOutput("midreset.pal", int'(pal_index), 0);
      checkOutput("midreset.valid", int'(pix_valid), 0);
      draw_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus("post_reset", 5, 3, 197, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got 0 expected 1");
      $fatal(1, "[TB] timeout");
   end

endmodule
